// File: rtl/conv_feeder.sv
// conv_feeder
// -----------
// Initiator that feeds conv_controller. A start pulse reads NUM_COEFF
// coefficients and then an IMG_W x IMG_H pixel frame from a synchronous
// source memory. Each word goes out on data_out together with a one-cycle
// coeff_load_en or sample_load_en pulse. new_row marks the first pixel of
// every row.
//
// Handshake: the controller drives modwait high while it is busy. A word
// is issued only from ARM on a cycle where modwait is low. A fixed GUARD
// cycle follows each issue so the controller has time to raise modwait
// before the next word. modwait is ignored in every other state.
//
// Ports:
//   clk, n_rst      rising-edge clock, synchronous active-low reset
//   start           begin a frame (sampled only in IDLE)
//   modwait         controller busy; holds the feeder in ARM
//   src_rd/src_addr source memory read strobe and address
//   src_data        read data, valid the cycle after src_rd
//   data_out        word presented to the controller
//   coeff_load_en   one-cycle coefficient load pulse
//   sample_load_en  one-cycle sample load pulse
//   new_row         first pixel of a row (only with sample_load_en)
//   busy            high in every state except IDLE
//   done            one-cycle pulse at frame completion
module conv_feeder #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 8,
  parameter int NUM_COEFF = 4,
  parameter int IMG_W     = 8,
  parameter int IMG_H     = 8
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              start,
  input  logic              modwait,
  output logic              src_rd,
  output logic [ADDR_W-1:0] src_addr,
  input  logic [DATA_W-1:0] src_data,
  output logic [DATA_W-1:0] data_out,
  output logic              coeff_load_en,
  output logic              sample_load_en,
  output logic              new_row,
  output logic              busy,
  output logic              done
);

  localparam int NUM_ITEMS = NUM_COEFF + IMG_W * IMG_H;
  localparam int COL_W     = (IMG_W > 1) ? $clog2(IMG_W) : 1;

  localparam logic [ADDR_W-1:0] LAST_ITEM = ADDR_W'(NUM_ITEMS - 1);
  localparam logic [ADDR_W-1:0] COEFF_END = ADDR_W'(NUM_COEFF);
  localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(IMG_W - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RD    = 3'd1,
    S_CAP   = 3'd2,
    S_ARM   = 3'd3,
    S_ISSUE = 3'd4,
    S_GUARD = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   item_q, item_d;
  logic [COL_W-1:0]    col_q, col_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                is_sample;

  // Items at or beyond NUM_COEFF are pixels.
  assign is_sample = (item_q >= COEFF_END);

  // State register
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q <= S_IDLE;
      item_q  <= '0;
      col_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      item_q  <= item_d;
      col_q   <= col_d;
      data_q  <= data_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    item_d  = item_q;
    col_d   = col_q;
    data_d  = data_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RD;
          item_d  = '0;
          col_d   = '0;
        end
      end
      S_RD:    state_d = S_CAP;
      S_CAP: begin
        // Memory data for the address issued in RD is valid now.
        data_d  = src_data;
        state_d = S_ARM;
      end
      S_ARM: begin
        if (!modwait) state_d = S_ISSUE;
      end
      S_ISSUE: state_d = S_GUARD;
      S_GUARD: begin
        // Column counter only advances over pixels, wrapping per row.
        if (is_sample) begin
          col_d = (col_q == COL_LAST) ? '0 : col_q + 1'b1;
        end
        if (item_q == LAST_ITEM) begin
          state_d = S_DONE;
        end else begin
          item_d  = item_q + 1'b1;
          state_d = S_RD;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode from registered state only
  always_comb begin
    src_rd         = 1'b0;
    src_addr       = '0;
    coeff_load_en  = 1'b0;
    sample_load_en = 1'b0;
    new_row        = 1'b0;
    busy           = (state_q != S_IDLE);
    done           = 1'b0;
    unique case (state_q)
      S_RD: begin
        src_rd   = 1'b1;
        src_addr = item_q;
      end
      S_ISSUE: begin
        coeff_load_en  = !is_sample;
        sample_load_en = is_sample;
        new_row        = is_sample && (col_q == '0);
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  assign data_out = data_q;

endmodule

// File: tb/tb_conv_feeder.sv
// Bench for conv_feeder: directed frames with randomized memory contents,
// stalls and modwait/start noise, checked cycle by cycle against a
// schedule computed from the per-item timing rules.
module tb_conv_feeder;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 8;
  localparam int NC     = 4;
  localparam int IW     = 8;
  localparam int IH     = 8;
  localparam int NI     = NC + IW * IH;

  // clock / reset block
  logic clk = 1'b0;
  logic n_rst;
  always #5 clk = ~clk;

  logic              start, modwait, src_rd;
  logic [ADDR_W-1:0] src_addr;
  logic [DATA_W-1:0] src_data, data_out;
  logic              coeff_load_en, sample_load_en, new_row, busy, done;

  conv_feeder #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_COEFF(NC), .IMG_W(IW), .IMG_H(IH)
  ) dut (
    .clk(clk), .n_rst(n_rst), .start(start), .modwait(modwait),
    .src_rd(src_rd), .src_addr(src_addr), .src_data(src_data),
    .data_out(data_out), .coeff_load_en(coeff_load_en),
    .sample_load_en(sample_load_en), .new_row(new_row),
    .busy(busy), .done(done)
  );

  // synchronous source memory
  logic [DATA_W-1:0] mem [0:255];
  always_ff @(posedge clk) if (src_rd) src_data <= mem[src_addr];

  int cyc = 0;
  always @(posedge clk) cyc++;

  int errors = 0;
  int checks = 0;
  int stall [0:NI-1];
  logic [DATA_W-1:0] exp_data;
  int last_pulse_cyc = -1;
  int n_coeff, n_samp, n_row, first_samp_rel, done_seen_rel;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic check_idle(input string tag);
    chk({tag, ".src_rd"}, src_rd, 0);
    chk({tag, ".coeff_load_en"}, coeff_load_en, 0);
    chk({tag, ".sample_load_en"}, sample_load_en, 0);
    chk({tag, ".new_row"}, new_row, 0);
    chk({tag, ".busy"}, busy, 0);
    chk({tag, ".done"}, done, 0);
    chk({tag, ".data_out"}, data_out, exp_data);
  endtask

  // Drives one frame from an IDLE negedge. Item k starts (RD) at relative
  // cycle st[k]; its load pulse comes 3+stall[k] cycles later.
  task automatic run_frame(input int abort_rel, input bit hold_start,
                           input bit rand_mw, input bit rand_start, input int start_at);
    int st [0:NI];
    int i, off, done_rel;
    bit e_rd, e_ce, e_se, e_nr, e_done, issue;
    st[0] = 1;
    for (int k = 0; k < NI; k++) st[k+1] = st[k] + 5 + stall[k];
    done_rel = st[NI];
    n_coeff = 0; n_samp = 0; n_row = 0; first_samp_rel = -1; done_seen_rel = -1;
    start = 1'b1;
    modwait = rand_mw ? 1'($urandom_range(0, 1)) : 1'b0;
    @(negedge clk);
    i = 0;
    for (int rel = 1; rel <= done_rel; rel++) begin
      while (i < NI && rel >= st[i+1]) i++;
      off = rel - st[i];
      if (i < NI) begin
        issue  = (off == 3 + stall[i]);
        e_rd   = (off == 0);
        e_ce   = issue && (i < NC);
        e_se   = issue && (i >= NC);
        e_nr   = e_se && (((i - NC) % IW) == 0);
        e_done = 1'b0;
        if (off == 2) exp_data = mem[i];
      end else begin
        e_rd = 0; e_ce = 0; e_se = 0; e_nr = 0; e_done = 1'b1;
      end
      // observations taken from the DUT
      if (sample_load_en) begin
        n_samp++;
        if (first_samp_rel < 0) first_samp_rel = rel;
      end
      if (coeff_load_en) n_coeff++;
      if (new_row) n_row++;
      if (done) done_seen_rel = rel;
      if (coeff_load_en || sample_load_en) begin
        if (last_pulse_cyc >= 0) chk("pulse_gap_ge5", 32'(cyc - last_pulse_cyc >= 5), 1);
        last_pulse_cyc = cyc;
      end
      chk("src_rd", src_rd, e_rd);
      if (e_rd) chk("src_addr", src_addr, i);
      chk("coeff_load_en", coeff_load_en, e_ce);
      chk("sample_load_en", sample_load_en, e_se);
      chk("new_row", new_row, e_nr);
      chk("busy", busy, 1);
      chk("done", done, e_done);
      chk("data_out", data_out, exp_data);
      if (rel == abort_rel) begin
        n_rst = 1'b0;
        start = 1'b0;
        @(negedge clk);
        exp_data = '0;
        check_idle("after_reset");
        chk("after_reset.src_addr", src_addr, 0);
        n_rst = 1'b1;
        return;
      end
      // inputs for the edge that ends this cycle
      if (i < NI && off >= 2 && off <= 2 + stall[i])
        modwait = (off < 2 + stall[i]);
      else
        modwait = rand_mw ? 1'($urandom_range(0, 1)) : 1'b0;
      if (rel == done_rel)      start = hold_start;
      else if (rel == start_at) start = 1'b1;
      else                      start = rand_start ? ($urandom_range(0, 3) == 0) : 1'b0;
      @(negedge clk);
    end
    check_idle("idle_after_done");
    chk("frame.samples", n_samp, IW * IH);
    chk("frame.coeffs", n_coeff, NC);
    chk("frame.rows", n_row, IH);
    chk("frame.done_cycle", done_seen_rel, done_rel);
    if (!hold_start) start = 1'b0;
  endtask

  initial begin
    n_rst = 1'b0;
    start = 1'b1;
    modwait = 1'b0;
    exp_data = '0;
    for (int a = 0; a < 256; a++) mem[a] = 8'(a + 16);
    for (int k = 0; k < NI; k++) stall[k] = 0;

    // reset with start held high
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_idle("reset");
    chk("reset.src_addr", src_addr, 0);
    n_rst = 1'b1;
    start = 1'b0;
    repeat (10) begin
      @(negedge clk);
      check_idle("idle_hold");
    end

    // full frame, no back-pressure, stray start at cycle 100
    run_frame(0, 1'b0, 1'b0, 1'b0, 100);
    chk("frameA.first_sample", first_samp_rel, 24);
    chk("frameA.done_at", done_seen_rel, 341);

    // 7-cycle stall in ARM before the 2nd coefficient
    stall[1] = 7;
    run_frame(0, 1'b0, 1'b1, 1'b1, -1);
    chk("stall.first_sample", first_samp_rel, 31);
    chk("stall.done_at", done_seen_rel, 348);

    // random data and stalls, start held through DONE
    for (int a = 0; a < NI; a++) mem[a] = 8'($urandom_range(0, 255));
    for (int k = 0; k < NI; k++) stall[k] = $urandom_range(0, 3);
    run_frame(0, 1'b1, 1'b1, 1'b1, -1);

    // back-to-back frame, reset during ISSUE of sample 10 (item 14)
    for (int k = 0; k < NI; k++) stall[k] = 0;
    run_frame(74, 1'b0, 1'b0, 1'b0, -1);

    // restart after reset must begin at address 0 with coefficients
    for (int k = 0; k < NI; k++) stall[k] = $urandom_range(0, 2);
    run_frame(0, 1'b0, 1'b1, 1'b0, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
